// File: rtl/reg_file.sv
// Architectural register file with per-register rename tags.
// Holds the 32 committed register values plus the ROB tag of the in-flight
// producer of each register, serves two combinational operand lookups with a
// same-cycle commit bypass, and retires ROB commits.
// Optional feature macro: REG_PERF_CNT_EN adds the commit/rollback debug
// counters; when it is undefined both counter outputs are constant zero.
module reg_file #(
  parameter int REG_NUM  = 32,
  parameter int ROB_ID_W = 5,
  parameter int DATA_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  // operand lookup
  input  logic [4:0]          rs1_from_cmd,
  input  logic [4:0]          rs2_from_cmd,
  output logic [ROB_ID_W-1:0] Q1_to_cmd,
  output logic [ROB_ID_W-1:0] Q2_to_cmd,
  output logic [DATA_W-1:0]   V1_to_cmd,
  output logic [DATA_W-1:0]   V2_to_cmd,
  // rename request
  input  logic                enable_sign_from_cmd,
  input  logic [4:0]          rd_from_cmd,
  input  logic [ROB_ID_W-1:0] rob_id_from_cmd,
  // commit / rollback from the ROB
  input  logic                commit_sign,
  input  logic [4:0]          rd_from_rob,
  input  logic [ROB_ID_W-1:0] Q_from_rob,
  input  logic [DATA_W-1:0]   V_from_rob,
  input  logic                rollback_sign,
  // debug counters
  output logic [31:0]         commit_cnt,
  output logic [31:0]         rollback_cnt
);

  logic [DATA_W-1:0]   v_q [REG_NUM];
  logic [DATA_W-1:0]   v_d [REG_NUM];
  logic [ROB_ID_W-1:0] q_q [REG_NUM];
  logic [ROB_ID_W-1:0] q_d [REG_NUM];

  logic commit_wr;
  assign commit_wr = commit_sign && (rd_from_rob != 5'd0);

  // Next-state of the value and tag arrays: commit, then rollback or rename.
  always_comb begin
    // NOTE: start from the current state so every element has a value on
    // every path; a missing default here would infer latches.
    v_d = v_q;
    q_d = q_q;
    if (commit_wr) begin
      v_d[rd_from_rob] = V_from_rob;
      // A mismatching tag means a younger rename is still live; keep it.
      if (q_q[rd_from_rob] == Q_from_rob) q_d[rd_from_rob] = '0;
    end
    if (rollback_sign) begin
      for (int i = 0; i < REG_NUM; i++) q_d[i] = '0;
    end else if (enable_sign_from_cmd && (rd_from_cmd != 5'd0)) begin
      // Applied after the commit clear so a same-cycle rename wins.
      q_d[rd_from_cmd] = rob_id_from_cmd;
    end
  end

  // Array state register: synchronous reset, hold while rdy is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the arrays are reset explicitly because a freshly reset core
      // must read every register as value 0 with no pending rename; this
      // keeps the storage in flops rather than a RAM macro.
      for (int i = 0; i < REG_NUM; i++) begin
        v_q[i] <= '0;
        q_q[i] <= '0;
      end
    end else if (rdy) begin
      // NOTE: non-blocking assignments for all sequential state so every
      // flop samples the pre-edge values.
      for (int i = 0; i < REG_NUM; i++) begin
        v_q[i] <= v_d[i];
        q_q[i] <= q_d[i];
      end
    end
  end

  // Operand port 1: x0 reads zero, same-cycle matching commit bypasses.
  always_comb begin
    Q1_to_cmd = q_q[rs1_from_cmd];
    V1_to_cmd = v_q[rs1_from_cmd];
    if (rs1_from_cmd == 5'd0) begin
      Q1_to_cmd = '0;
      V1_to_cmd = '0;
    end else if (commit_sign && (rd_from_rob == rs1_from_cmd) &&
                 (q_q[rs1_from_cmd] == Q_from_rob)) begin
      Q1_to_cmd = '0;
      V1_to_cmd = V_from_rob;
    end
  end

  // Operand port 2: same rules as port 1.
  always_comb begin
    Q2_to_cmd = q_q[rs2_from_cmd];
    V2_to_cmd = v_q[rs2_from_cmd];
    if (rs2_from_cmd == 5'd0) begin
      Q2_to_cmd = '0;
      V2_to_cmd = '0;
    end else if (commit_sign && (rd_from_rob == rs2_from_cmd) &&
                 (q_q[rs2_from_cmd] == Q_from_rob)) begin
      Q2_to_cmd = '0;
      V2_to_cmd = V_from_rob;
    end
  end

`ifdef REG_PERF_CNT_EN
  logic [31:0] commit_cnt_q, commit_cnt_d;
  logic [31:0] rollback_cnt_q, rollback_cnt_d;

  // Counter next-state: count strobes, wrapping modulo 2^32.
  always_comb begin
    commit_cnt_d   = commit_cnt_q + 32'(commit_sign);
    rollback_cnt_d = rollback_cnt_q + 32'(rollback_sign);
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      commit_cnt_q   <= '0;
      rollback_cnt_q <= '0;
    end else if (rdy) begin
      commit_cnt_q   <= commit_cnt_d;
      rollback_cnt_q <= rollback_cnt_d;
    end
  end

  assign commit_cnt   = commit_cnt_q;
  assign rollback_cnt = rollback_cnt_q;
`else
  assign commit_cnt   = '0;
  assign rollback_cnt = '0;
`endif

endmodule

// File: tb/tb_reg_file.sv
// Directed testbench for reg_file: rename, commit, bypass, rollback,
// rdy hold, x0 handling and the optional debug counters.
module tb_reg_file;

  localparam int ROB_ID_W = 5;
  localparam int DATA_W   = 32;

  logic                clk = 1'b0;
  logic                rst, rdy;
  logic [4:0]          rs1_from_cmd, rs2_from_cmd;
  logic [ROB_ID_W-1:0] Q1_to_cmd, Q2_to_cmd;
  logic [DATA_W-1:0]   V1_to_cmd, V2_to_cmd;
  logic                enable_sign_from_cmd;
  logic [4:0]          rd_from_cmd;
  logic [ROB_ID_W-1:0] rob_id_from_cmd;
  logic                commit_sign;
  logic [4:0]          rd_from_rob;
  logic [ROB_ID_W-1:0] Q_from_rob;
  logic [DATA_W-1:0]   V_from_rob;
  logic                rollback_sign;
  logic [31:0]         commit_cnt, rollback_cnt;

  int checks   = 0;
  int failures = 0;

  reg_file #(.REG_NUM(32), .ROB_ID_W(ROB_ID_W), .DATA_W(DATA_W)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .rdy                  (rdy),
    .rs1_from_cmd         (rs1_from_cmd),
    .rs2_from_cmd         (rs2_from_cmd),
    .Q1_to_cmd            (Q1_to_cmd),
    .Q2_to_cmd            (Q2_to_cmd),
    .V1_to_cmd            (V1_to_cmd),
    .V2_to_cmd            (V2_to_cmd),
    .enable_sign_from_cmd (enable_sign_from_cmd),
    .rd_from_cmd          (rd_from_cmd),
    .rob_id_from_cmd      (rob_id_from_cmd),
    .commit_sign          (commit_sign),
    .rd_from_rob          (rd_from_rob),
    .Q_from_rob           (Q_from_rob),
    .V_from_rob           (V_from_rob),
    .rollback_sign        (rollback_sign),
    .commit_cnt           (commit_cnt),
    .rollback_cnt         (rollback_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected counter value: the raw count when the counters exist, else 0.
  function automatic logic [31:0] cnt_exp(input int n);
`ifdef REG_PERF_CNT_EN
    return 32'(n);
`else
    return (n == 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    enable_sign_from_cmd = 1'b0;
    commit_sign          = 1'b0;
    rollback_sign        = 1'b0;
  endtask

  task automatic rename(input logic [4:0] rd, input logic [ROB_ID_W-1:0] tag);
    enable_sign_from_cmd = 1'b1;
    rd_from_cmd          = rd;
    rob_id_from_cmd      = tag;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [ROB_ID_W-1:0] tag,
                        input logic [DATA_W-1:0] val);
    commit_sign = 1'b1;
    rd_from_rob = rd;
    Q_from_rob  = tag;
    V_from_rob  = val;
  endtask

  task automatic read1(input logic [4:0] rs);
    rs1_from_cmd = rs;
    #1;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1;
    rs1_from_cmd = '0; rs2_from_cmd = '0;
    rd_from_cmd = '0; rob_id_from_cmd = '0;
    rd_from_rob = '0; Q_from_rob = '0; V_from_rob = '0;
    idle();
    tick(); tick();
    rst = 1'b0;

    // Reset state
    rs1_from_cmd = 5'd5; rs2_from_cmd = 5'd0; #1;
    check("rst_q1", 32'(Q1_to_cmd), 32'd0);
    check("rst_v1", V1_to_cmd, 32'd0);
    check("rst_q2", 32'(Q2_to_cmd), 32'd0);
    check("rst_v2", V2_to_cmd, 32'd0);
    check("rst_ccnt", commit_cnt, cnt_exp(0));
    check("rst_rcnt", rollback_cnt, cnt_exp(0));

    // Rename x3 -> tag 4, then commit with same-cycle bypass
    rename(5'd3, 5'd4);
    tick(); idle();
    rs2_from_cmd = 5'd3; read1(5'd3);
    check("ren3_q1", 32'(Q1_to_cmd), 32'd4);
    check("ren3_q2", 32'(Q2_to_cmd), 32'd4);
    commit(5'd3, 5'd4, 32'h1234); #1;
    check("byp3_q1", 32'(Q1_to_cmd), 32'd0);
    check("byp3_v1", V1_to_cmd, 32'h1234);
    check("byp3_v2", V2_to_cmd, 32'h1234);
    tick(); idle(); #1;
    check("com3_q1", 32'(Q1_to_cmd), 32'd0);
    check("com3_v1", V1_to_cmd, 32'h1234);
    check("com3_ccnt", commit_cnt, cnt_exp(1));

    // Stale-tag commit keeps the younger rename
    rename(5'd7, 5'd2); tick();
    rename(5'd7, 5'd6); tick(); idle();
    commit(5'd7, 5'd2, 32'hAA); read1(5'd7);
    check("stale7_nobyp_q", 32'(Q1_to_cmd), 32'd6);
    check("stale7_nobyp_v", V1_to_cmd, 32'd0);
    tick(); idle(); #1;
    check("stale7_q", 32'(Q1_to_cmd), 32'd6);
    check("stale7_v", V1_to_cmd, 32'hAA);

    // Same-cycle commit and rename to x9: rename wins the tag
    commit(5'd9, 5'd1, 32'h55); rename(5'd9, 5'd3);
    tick(); idle(); read1(5'd9);
    check("same9_q", 32'(Q1_to_cmd), 32'd3);
    check("same9_v", V1_to_cmd, 32'h55);
    check("same9_ccnt", commit_cnt, cnt_exp(3));

    // Rollback with pending renames, concurrent commit and rename
    rename(5'd1, 5'd1); tick();
    rename(5'd2, 5'd2); tick();
    rename(5'd31, 5'd7); tick(); idle(); read1(5'd31);
    check("pre_rb_q31", 32'(Q1_to_cmd), 32'd7);
    rollback_sign = 1'b1; commit(5'd1, 5'd9, 32'h77); rename(5'd4, 5'd5);
    tick(); idle();
    rs2_from_cmd = 5'd4; read1(5'd1);
    check("rb_q1", 32'(Q1_to_cmd), 32'd0);
    check("rb_v1", V1_to_cmd, 32'h77);
    check("rb_q4", 32'(Q2_to_cmd), 32'd0);
    read1(5'd31); check("rb_q31", 32'(Q1_to_cmd), 32'd0);
    read1(5'd7);  check("rb_q7", 32'(Q1_to_cmd), 32'd0);
    check("rb_v7", V1_to_cmd, 32'hAA);
    read1(5'd9);  check("rb_q9", 32'(Q1_to_cmd), 32'd0);
    check("rb_rcnt", rollback_cnt, cnt_exp(1));
    check("rb_ccnt", commit_cnt, cnt_exp(4));

    // rdy low holds all state
    rdy = 1'b0; rename(5'd8, 5'd2); commit(5'd8, 5'd0, 32'h9); rollback_sign = 1'b1;
    tick(); idle(); rdy = 1'b1; read1(5'd8);
    check("hold8_q", 32'(Q1_to_cmd), 32'd0);
    check("hold8_v", V1_to_cmd, 32'd0);
    check("hold_ccnt", commit_cnt, cnt_exp(4));
    check("hold_rcnt", rollback_cnt, cnt_exp(1));

    // x0 write/rename ignored, commit still counted
    commit(5'd0, 5'd0, 32'hFFFF); rename(5'd0, 5'd3); read1(5'd0);
    check("x0_byp_q", 32'(Q1_to_cmd), 32'd0);
    check("x0_byp_v", V1_to_cmd, 32'd0);
    tick(); idle(); #1;
    check("x0_q", 32'(Q1_to_cmd), 32'd0);
    check("x0_v", V1_to_cmd, 32'd0);
    check("x0_ccnt", commit_cnt, cnt_exp(5));

    // Tag-0 commit onto a renamed register: value write only
    rename(5'd10, 5'd5); tick(); idle();
    commit(5'd10, 5'd0, 32'h42); tick(); idle(); read1(5'd10);
    check("tag0_q", 32'(Q1_to_cmd), 32'd5);
    check("tag0_v", V1_to_cmd, 32'h42);

    // Reset overrides rdy low
    rdy = 1'b0; rst = 1'b1; tick(); rst = 1'b0; rdy = 1'b1; read1(5'd10);
    check("rst2_q10", 32'(Q1_to_cmd), 32'd0);
    check("rst2_v10", V1_to_cmd, 32'd0);
    read1(5'd3); check("rst2_v3", V1_to_cmd, 32'd0);
    check("rst2_ccnt", commit_cnt, cnt_exp(0));
    check("rst2_rcnt", rollback_cnt, cnt_exp(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
